cache_ctrl_nway: RTL and testbench

//  Control FSM for the N-way set-associative, write-back, write-allocate data cache. Successor
//  to the fixed 2-way controller: parametrised way count and victim selection by the external

---
 rtl/cache_ctrl_nway_if.sv | 50 +++++
 rtl/cache_ctrl_nway.sv | 179 +++++++++++++++++
 tb/tb_cache_ctrl_nway.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_ctrl_nway_if.sv
// Bundle of CPU, tag/data array, memory and statistics signals for the N-way cache controller.
// master = controller side, slave = surrounding datapath/environment side.
interface cache_ctrl_nway_if #(
    parameter int unsigned WAYS   = 2,
    parameter int unsigned STAT_W = 16
);
    localparam int unsigned WAY_W = $clog2(WAYS);

    logic              cpu_read;
    logic              cpu_write;
    logic [WAYS-1:0]   hit_vec;
    logic [WAYS-1:0]   valid_vec;
    logic [WAYS-1:0]   dirty_vec;
    logic [WAY_W-1:0]  victim_way;
    logic              mem_resp;
    logic              stat_clr;

    logic              cpu_resp;
    logic              mem_read;
    logic              mem_write;
    logic              wb_addr_sel;
    logic              data_in_sel;
    logic [WAYS-1:0]   load_line;
    logic [WAYS-1:0]   load_bytes;
    logic [WAYS-1:0]   load_tag;
    logic [WAYS-1:0]   set_valid;
    logic [WAYS-1:0]   write_valid;
    logic [WAYS-1:0]   set_dirty;
    logic [WAYS-1:0]   write_dirty;
    logic              repl_update;
    logic [WAY_W-1:0]  repl_way;
    logic              error;
    logic [STAT_W-1:0] hit_cnt;
    logic [STAT_W-1:0] miss_cnt;
    logic [STAT_W-1:0] wb_cnt;

    modport master (
        input  cpu_read, cpu_write, hit_vec, valid_vec, dirty_vec, victim_way, mem_resp, stat_clr,
        output cpu_resp, mem_read, mem_write, wb_addr_sel, data_in_sel, load_line, load_bytes,
               load_tag, set_valid, write_valid, set_dirty, write_dirty, repl_update, repl_way,
               error, hit_cnt, miss_cnt, wb_cnt
    );

    modport slave (
        output cpu_read, cpu_write, hit_vec, valid_vec, dirty_vec, victim_way, mem_resp, stat_clr,
        input  cpu_resp, mem_read, mem_write, wb_addr_sel, data_in_sel, load_line, load_bytes,
               load_tag, set_valid, write_valid, set_dirty, write_dirty, repl_update, repl_way,
               error, hit_cnt, miss_cnt, wb_cnt
    );
endinterface

// File: rtl/cache_ctrl_nway.sv
// Control FSM for an N-way set-associative write-back, write-allocate data cache with memory
// timeout, multi-hit detection and saturating hit/miss/writeback statistics.
module cache_ctrl_nway #(
    parameter int unsigned WAYS        = 2,
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned STAT_W      = 16
) (
    input logic               clk,
    input logic               rst_n,
    cache_ctrl_nway_if.master bus
);
    localparam int unsigned WAY_W = $clog2(WAYS);
    localparam int unsigned TMO_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);
    localparam logic [STAT_W-1:0] STAT_MAX = '1;

    typedef enum logic [2:0] {StIdle, StLookup, StWbWait, StFillWait, StError} state_e;
    typedef enum logic {OpRd, OpWr} op_e;

    state_e            state_q;
    op_e               op_q;
    logic [WAY_W-1:0]  victim_q;
    logic [TMO_W-1:0]  tmo_q;
    logic [STAT_W-1:0] hit_cnt_q, miss_cnt_q, wb_cnt_q;

    logic [WAYS-1:0]  hv;
    logic [WAYS-1:0]  hit_oh;
    logic [WAYS-1:0]  victim_oh;
    logic [WAY_W-1:0] hit_idx;
    logic             any_hit, multi_hit, single_hit;
    logic             victim_dirty;
    logic             tmo_expired;
    logic             hit_evt, miss_evt, wb_evt;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == STAT_MAX) ? v : v + 1'b1;
    endfunction

    // Qualified hit decode: a second set bit marks the lookup as a multi-hit.
    always_comb begin
        hv        = bus.hit_vec & bus.valid_vec;
        hit_idx   = '0;
        any_hit   = 1'b0;
        multi_hit = 1'b0;
        for (int unsigned i = 0; i < WAYS; i++) begin
            if (hv[i]) begin
                if (any_hit) multi_hit = 1'b1;
                any_hit = 1'b1;
                hit_idx = WAY_W'(i);
            end
        end
        hit_oh            = '0;
        hit_oh[hit_idx]   = 1'b1;
        victim_oh         = '0;
        victim_oh[victim_q] = 1'b1;
    end

    assign single_hit   = any_hit && !multi_hit;
    assign victim_dirty = bus.valid_vec[bus.victim_way] && bus.dirty_vec[bus.victim_way];
    assign tmo_expired  = (tmo_q == TMO_LAST) && !bus.mem_resp;
    assign hit_evt      = (state_q == StLookup) && single_hit;
    assign miss_evt     = (state_q == StLookup) && !any_hit;
    assign wb_evt       = (state_q == StWbWait) && bus.mem_resp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            op_q     <= OpRd;
            victim_q <= '0;
            tmo_q    <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.cpu_write) begin
                        op_q    <= OpWr;
                        state_q <= StLookup;
                    end else if (bus.cpu_read) begin
                        op_q    <= OpRd;
                        state_q <= StLookup;
                    end
                end
                StLookup: begin
                    if (multi_hit) begin
                        state_q <= StError;
                    end else if (any_hit) begin
                        state_q <= StIdle;
                    end else begin
                        victim_q <= bus.victim_way;
                        tmo_q    <= '0;
                        state_q  <= victim_dirty ? StWbWait : StFillWait;
                    end
                end
                StWbWait, StFillWait: begin
                    // A response on the last allowed cycle still counts as in time.
                    if (bus.mem_resp) begin
                        tmo_q   <= '0;
                        state_q <= (state_q == StWbWait) ? StFillWait : StLookup;
                    end else if (tmo_expired) begin
                        state_q <= StError;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                StError: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            wb_cnt_q   <= '0;
        end else if (bus.stat_clr) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            wb_cnt_q   <= '0;
        end else begin
            if (hit_evt)  hit_cnt_q  <= sat_inc(hit_cnt_q);
            if (miss_evt) miss_cnt_q <= sat_inc(miss_cnt_q);
            if (wb_evt)   wb_cnt_q   <= sat_inc(wb_cnt_q);
        end
    end

    assign bus.hit_cnt  = hit_cnt_q;
    assign bus.miss_cnt = miss_cnt_q;
    assign bus.wb_cnt   = wb_cnt_q;

    always_comb begin
        bus.cpu_resp    = 1'b0;
        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b0;
        bus.wb_addr_sel = 1'b0;
        bus.data_in_sel = 1'b0;
        bus.load_line   = '0;
        bus.load_bytes  = '0;
        bus.load_tag    = '0;
        bus.set_valid   = '0;
        bus.write_valid = '0;
        bus.set_dirty   = '0;
        bus.write_dirty = '0;
        bus.repl_update = 1'b0;
        bus.repl_way    = '0;
        bus.error       = 1'b0;
        case (state_q)
            StLookup: begin
                if (single_hit) begin
                    bus.cpu_resp    = 1'b1;
                    bus.repl_update = 1'b1;
                    bus.repl_way    = hit_idx;
                    if (op_q == OpWr) begin
                        bus.load_bytes  = hit_oh;
                        bus.set_dirty   = hit_oh;
                        bus.write_dirty = hit_oh;
                    end
                end
            end
            StWbWait: begin
                bus.mem_write   = 1'b1;
                bus.wb_addr_sel = 1'b1;
            end
            StFillWait: begin
                bus.mem_read = 1'b1;
                // Fresh line lands clean: dirty written to 0 alongside valid.
                if (bus.mem_resp) begin
                    bus.load_line   = victim_oh;
                    bus.load_tag    = victim_oh;
                    bus.data_in_sel = 1'b1;
                    bus.set_valid   = victim_oh;
                    bus.write_valid = victim_oh;
                    bus.write_dirty = victim_oh;
                end
            end
            StError: bus.error = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_cache_ctrl_nway.sv
// Self-checking bench for cache_ctrl_nway: transaction-level model drives each request and
// predicts every output per cycle; a negedge process compares the DUT against it.
module tb_cache_ctrl_nway;
    localparam int unsigned WAYS   = 4;
    localparam int unsigned T      = 8;
    localparam int unsigned STAT_W = 2;
    localparam int          SMAX   = (1 << STAT_W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cache_ctrl_nway_if #(.WAYS(WAYS), .STAT_W(STAT_W)) bus ();

    cache_ctrl_nway #(.WAYS(WAYS), .MEM_TIMEOUT(T), .STAT_W(STAT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;
    int clr_rate = 0;

    logic       exp_cpu_resp, exp_mem_read, exp_mem_write, exp_wb_addr_sel, exp_data_in_sel;
    logic [3:0] exp_load_line, exp_load_bytes, exp_load_tag, exp_set_valid, exp_write_valid;
    logic [3:0] exp_set_dirty, exp_write_dirty;
    logic       exp_repl_update, exp_error;
    logic [1:0] exp_repl_way;
    int         exp_hit, exp_miss, exp_wb;

    int m_hit, m_miss, m_wb;
    bit ev_hit, ev_miss, ev_wb;
    int obs_cyc, obs_resp_at, obs_mw, obs_mr;
    bit obs_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("cpu_resp", 32'(bus.cpu_resp), 32'(exp_cpu_resp));
            chk("mem_read", 32'(bus.mem_read), 32'(exp_mem_read));
            chk("mem_write", 32'(bus.mem_write), 32'(exp_mem_write));
            chk("wb_addr_sel", 32'(bus.wb_addr_sel), 32'(exp_wb_addr_sel));
            chk("data_in_sel", 32'(bus.data_in_sel), 32'(exp_data_in_sel));
            chk("load_line", 32'(bus.load_line), 32'(exp_load_line));
            chk("load_bytes", 32'(bus.load_bytes), 32'(exp_load_bytes));
            chk("load_tag", 32'(bus.load_tag), 32'(exp_load_tag));
            chk("set_valid", 32'(bus.set_valid), 32'(exp_set_valid));
            chk("write_valid", 32'(bus.write_valid), 32'(exp_write_valid));
            chk("set_dirty", 32'(bus.set_dirty), 32'(exp_set_dirty));
            chk("write_dirty", 32'(bus.write_dirty), 32'(exp_write_dirty));
            chk("repl_update", 32'(bus.repl_update), 32'(exp_repl_update));
            chk("repl_way", 32'(bus.repl_way), 32'(exp_repl_way));
            chk("error", 32'(bus.error), 32'(exp_error));
            chk("hit_cnt", 32'(bus.hit_cnt), 32'(exp_hit));
            chk("miss_cnt", 32'(bus.miss_cnt), 32'(exp_miss));
            chk("wb_cnt", 32'(bus.wb_cnt), 32'(exp_wb));
        end
    end

    function automatic logic [3:0] oh(input int idx);
        logic [3:0] v;
        v = 4'b0001;
        return v << idx;
    endfunction

    function automatic int first_idx(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic int sat(input int v);
        return (v > SMAX) ? SMAX : v;
    endfunction

    // Random don't-care inputs and all-zero expectations for a fresh cycle.
    task automatic bg();
        bus.hit_vec    = 4'($urandom);
        bus.valid_vec  = 4'($urandom);
        bus.dirty_vec  = 4'($urandom);
        bus.victim_way = 2'($urandom);
        bus.mem_resp   = ($urandom % 4) == 0;
        bus.stat_clr   = (clr_rate != 0) && (($urandom % clr_rate) == 0);
        exp_cpu_resp = 0; exp_mem_read = 0; exp_mem_write = 0; exp_wb_addr_sel = 0;
        exp_data_in_sel = 0; exp_load_line = 0; exp_load_bytes = 0; exp_load_tag = 0;
        exp_set_valid = 0; exp_write_valid = 0; exp_set_dirty = 0; exp_write_dirty = 0;
        exp_repl_update = 0; exp_repl_way = 0; exp_error = 0;
    endtask

    // One clock: publish expectations, sample at negedge, then advance the statistics model.
    task automatic step();
        bit clr;
        clr = bus.stat_clr;
        exp_hit = m_hit; exp_miss = m_miss; exp_wb = m_wb;
        @(negedge clk);
        obs_cyc++;
        if (bus.cpu_resp && obs_resp_at == 0) obs_resp_at = obs_cyc;
        if (bus.error) obs_err = 1'b1;
        if (bus.mem_write) obs_mw++;
        if (bus.mem_read) obs_mr++;
        @(posedge clk);
        if (clr) begin
            m_hit = 0; m_miss = 0; m_wb = 0;
        end else begin
            m_hit  = sat(m_hit + int'(ev_hit));
            m_miss = sat(m_miss + int'(ev_miss));
            m_wb   = sat(m_wb + int'(ev_wb));
        end
        ev_hit = 0; ev_miss = 0; ev_wb = 0;
        #1;
    endtask

    task automatic hit_exp(input bit wr, input int h);
        exp_cpu_resp = 1; exp_repl_update = 1; exp_repl_way = 2'(h); ev_hit = 1;
        if (wr) begin
            exp_load_bytes = oh(h); exp_set_dirty = oh(h); exp_write_dirty = oh(h);
        end
    endtask

    task automatic error_cycle();
        bg();
        bus.cpu_read = 0; bus.cpu_write = 0;
        exp_error = 1;
        step();
    endtask

    task automatic idle_cycle();
        bg();
        bus.cpu_read = 0; bus.cpu_write = 0;
        step();
    endtask

    // Memory wait phase; returns 0 when the response never comes within T cycles.
    task automatic mem_phase(input bit wb, input int dly, input int v, output bit ok);
        ok = 0;
        for (int i = 0; i < int'(T); i++) begin
            bg();
            bus.mem_resp = (i == dly);
            if (wb) begin
                exp_mem_write = 1; exp_wb_addr_sel = 1;
                if (i == dly) ev_wb = 1;
            end else begin
                exp_mem_read = 1;
                if (i == dly) begin
                    exp_load_line = oh(v); exp_load_tag = oh(v); exp_data_in_sel = 1;
                    exp_set_valid = oh(v); exp_write_valid = oh(v); exp_write_dirty = oh(v);
                end
            end
            step();
            if (i == dly) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic req(input bit wr, input bit rd_too, input logic [3:0] hit,
                       input logic [3:0] valid, input logic [3:0] dirty, input int vict,
                       input int wb_dly, input int fill_dly, input bit clr_lookup);
        logic [3:0] hv;
        bit ok;
        obs_cyc = 0; obs_resp_at = 0; obs_mw = 0; obs_mr = 0; obs_err = 0;
        bg();
        bus.cpu_write = wr;
        bus.cpu_read  = wr ? rd_too : 1'b1;
        step();
        bg();
        bus.hit_vec = hit; bus.valid_vec = valid; bus.dirty_vec = dirty;
        bus.victim_way = 2'(vict);
        if (clr_lookup) bus.stat_clr = 1;
        hv = hit & valid;
        if ($countones(hv) > 1) begin
            step();
            error_cycle();
            return;
        end
        if ($countones(hv) == 1) begin
            hit_exp(wr, first_idx(hv));
            step();
            return;
        end
        ev_miss = 1;
        step();
        if (valid[vict] && dirty[vict]) begin
            mem_phase(1, wb_dly, vict, ok);
            if (!ok) begin
                error_cycle();
                return;
            end
        end
        mem_phase(0, fill_dly, vict, ok);
        if (!ok) begin
            error_cycle();
            return;
        end
        bg();
        bus.hit_vec   = oh(vict);
        bus.valid_vec = 4'($urandom) | oh(vict);
        hit_exp(wr, vict);
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] hit, valid;
        int kind, a, b;
        bit rst_ok;
        bus.cpu_read = 0; bus.cpu_write = 0; bus.hit_vec = 0; bus.valid_vec = 0;
        bus.dirty_vec = 0; bus.victim_way = 0; bus.mem_resp = 0; bus.stat_clr = 0;
        m_hit = 0; m_miss = 0; m_wb = 0; ev_hit = 0; ev_miss = 0; ev_wb = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_cpu_resp", 32'(bus.cpu_resp), 0);
        chk("reset_mem_read", 32'(bus.mem_read), 0);
        chk("reset_error", 32'(bus.error), 0);
        chk("reset_hit_cnt", 32'(bus.hit_cnt), 0);
        rst_n = 1;
        check_en = 1;

        // Read hit on way 2: response in cycle 2.
        req(0, 0, 4'b0100, 4'b1111, 4'b0000, 0, 0, 0, 0);
        chk("hit_latency", 32'(obs_resp_at), 2);
        chk("hit_cnt_after_hit", 32'(bus.hit_cnt), 1);

        // Write miss, dirty victim 1: 3 writeback cycles, one fill, then the write hit.
        req(1, 0, 4'b0000, 4'b1111, 4'b0010, 1, 2, 0, 0);
        chk("wb_mem_write_cycles", 32'(obs_mw), 3);
        chk("wb_latency", 32'(obs_resp_at), 7);
        chk("wb_cnt_after_wb", 32'(bus.wb_cnt), 1);
        chk("miss_cnt_after_wb", 32'(bus.miss_cnt), 1);
        chk("hit_cnt_after_wb", 32'(bus.hit_cnt), 2);

        // Clean read miss with no memory response: timeout after T fill cycles.
        req(0, 0, 4'b0000, 4'b1111, 4'b0000, 3, 0, T, 0);
        chk("tmo_error_seen", 32'(obs_err), 1);
        chk("tmo_no_resp", 32'(obs_resp_at), 0);
        chk("tmo_fill_cycles", 32'(obs_mr), T);

        // Clean read miss, 2 wait cycles: 2+2+1+1.
        req(0, 0, 4'b0000, 4'b0110, 4'b1111, 0, 0, 2, 0);
        chk("miss_latency", 32'(obs_resp_at), 6);
        chk("miss_cnt_after_miss", 32'(bus.miss_cnt), 3);

        // Multi-hit.
        req(0, 0, 4'b0011, 4'b0011, 4'b0000, 0, 0, 0, 0);
        chk("multihit_error", 32'(obs_err), 1);
        chk("multihit_no_resp", 32'(obs_resp_at), 0);

        // Asynchronous reset while waiting for a fill.
        bg(); bus.cpu_read = 1; bus.cpu_write = 0; step();
        bg(); bus.hit_vec = 0; bus.valid_vec = 4'b1111; bus.dirty_vec = 0; bus.victim_way = 0;
        ev_miss = 1; step();
        bg(); bus.mem_resp = 0; exp_mem_read = 1; step();
        bg(); bus.mem_resp = 0;
        #1;
        chk("pre_reset_mem_read", 32'(bus.mem_read), 1);
        check_en = 0;
        rst_n = 0;
        bus.cpu_read = 0; bus.stat_clr = 0;
        #1;
        chk("reset_drops_mem_read", 32'(bus.mem_read), 0);
        rst_ok = (bus.hit_cnt == 0) && (bus.miss_cnt == 0) && (bus.wb_cnt == 0);
        chk("reset_clears_stats", 32'(rst_ok), 1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1;
        m_hit = 0; m_miss = 0; m_wb = 0; ev_hit = 0; ev_miss = 0; ev_wb = 0;
        check_en = 1;
        idle_cycle();

        // Saturation at 3 for STAT_W=2, then clear beating a same-cycle hit.
        for (int k = 0; k < 5; k++) req(0, 0, oh(k % 4), 4'b1111, 4'b0000, 0, 0, 0, 0);
        chk("hit_cnt_saturates", 32'(bus.hit_cnt), 3);
        req(0, 0, 4'b1000, 4'b1111, 4'b0000, 0, 0, 0, 1);
        chk("clr_beats_hit", 32'(bus.hit_cnt), 0);

        clr_rate = 16;
        for (int n = 0; n < 400; n++) begin
            if ($urandom % 4 == 0) idle_cycle();
            kind  = $urandom % 20;
            valid = 4'($urandom);
            hit   = 4'($urandom) & ~valid;
            if (kind < 10) begin
                a = $urandom % 4;
                valid |= oh(a); hit |= oh(a);
            end else if (kind < 13) begin
                a = $urandom % 4;
                b = (a + 1 + int'($urandom % 3)) % 4;
                valid |= oh(a) | oh(b); hit |= oh(a) | oh(b);
            end
            req($urandom % 2, $urandom % 2, hit, valid, 4'($urandom), $urandom % 4,
                $urandom_range(0, T), $urandom_range(0, T), 0);
        end
        idle_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
